// File: rtl/regfile_sb.sv
// regfile_sb: register file with power-on zero clear, optional write-to-read forwarding and a pending-write scoreboard
module regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wen,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] din,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] r1,
  output logic [XLEN-1:0] r2,
  input  logic            busy_set,
  input  logic [AW-1:0]   busy_rd,
  output logic            busy1,
  output logic            busy2,
  output logic            ready
);
  localparam logic [0:0]    CLEAR = 1'b0;
  localparam logic [0:0]    RUN   = 1'b1;
  localparam logic [AW-1:0] LAST  = AW'(NREGS - 1);
  localparam bit            FWD   = (BYPASS != 0);

  logic [0:0]      state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [NREGS-1:0] busy_q, busy_d;
  logic [XLEN-1:0] regs_q [NREGS];
  logic            run, wr, hit1, hit2, set1, set2;

  assign run   = (state_q == RUN);
  assign ready = run;
  assign wr    = run && wen && (rd != '0);

  // clear walks cnt across every register once, then parks in RUN without wrapping
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!run) begin
      state_d = (cnt_q == LAST) ? RUN : CLEAR;
      cnt_d   = (cnt_q == LAST) ? cnt_q : cnt_q + AW'(1);
    end
  end

  // scoreboard next state: a retiring write clears its bit, a new producer sets it and wins ties
  always_comb begin
    busy_d = run ? busy_q : '0;
    if (wr) busy_d[rd] = 1'b0;
    if (run && busy_set && (busy_rd != '0)) busy_d[busy_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // control and scoreboard flops, synchronous reset restarts the clear sweep
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // storage: zero fill during clear, architectural writes only once running
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (!run) regs_q[cnt_q] <= '0;
      else if (wr) regs_q[rd] <= din;
    end
  end

  assign hit1 = FWD && wr && (rd == rs1);
  assign hit2 = FWD && wr && (rd == rs2);
  assign set1 = busy_set && (busy_rd == rs1);
  assign set2 = busy_set && (busy_rd == rs2);

  assign r1    = (!run || rs1 == '0) ? '0 : (hit1 ? din : regs_q[rs1]);
  assign r2    = (!run || rs2 == '0) ? '0 : (hit2 ? din : regs_q[rs2]);
  assign busy1 = (!run || rs1 == '0 || (hit1 && !set1)) ? 1'b0 : busy_q[rs1];
  assign busy2 = (!run || rs2 == '0 || (hit2 && !set2)) ? 1'b0 : busy_q[rs2];
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: randomized and directed checks of regfile_sb against a behavioural model, bypass and no-bypass builds side by side
module tb_regfile_sb;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wen = 1'b0;
  logic        busy_set = 1'b0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0, busy_rd = '0;
  logic [31:0] din = '0;
  logic [31:0] r1v [2];
  logic [31:0] r2v [2];
  logic        b1v [2];
  logic        b2v [2];
  logic        rdyv [2];
  int          errors = 0;
  int          checks = 0;

  logic [31:0] m_regs [32];
  bit          m_busy [32];
  bit          m_ready = 1'b0;
  int          clear_left = 32;

  always #5 clk = ~clk;

  regfile_sb #(.XLEN(32), .NREGS(32), .BYPASS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .wen(wen), .rd(rd), .din(din), .rs1(rs1), .rs2(rs2),
    .r1(r1v[0]), .r2(r2v[0]), .busy_set(busy_set), .busy_rd(busy_rd),
    .busy1(b1v[0]), .busy2(b2v[0]), .ready(rdyv[0]));

  regfile_sb #(.XLEN(32), .NREGS(32), .BYPASS(0)) dut_n (
    .clk(clk), .rst_n(rst_n), .wen(wen), .rd(rd), .din(din), .rs1(rs1), .rs2(rs2),
    .r1(r1v[1]), .r2(r2v[1]), .busy_set(busy_set), .busy_rd(busy_rd),
    .busy1(b1v[1]), .busy2(b2v[1]), .ready(rdyv[1]));

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    if (!rst_n) begin
      clear_left = 32;
      m_ready = 1'b0;
      foreach (m_busy[i]) m_busy[i] = 1'b0;
    end else if (!m_ready) begin
      m_regs[32 - clear_left] = '0;
      clear_left--;
      m_ready = (clear_left == 0);
    end else begin
      if (wen && rd != 0) begin
        m_regs[rd] = din;
        m_busy[rd] = 1'b0;
      end
      if (busy_set && busy_rd != 0) m_busy[busy_rd] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_r(input logic [4:0] rs, input bit byp);
    if (!m_ready || rs == 0) return '0;
    if (byp && wen && rd == rs) return din;
    return m_regs[rs];
  endfunction

  function automatic logic exp_b(input logic [4:0] rs, input bit byp);
    if (!m_ready || rs == 0) return 1'b0;
    if (byp && wen && rd == rs && !(busy_set && busy_rd == rs)) return 1'b0;
    return m_busy[rs];
  endfunction

  task automatic idle();
    wen = 1'b0; busy_set = 1'b0; rd = '0; busy_rd = '0; din = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wen = 1'b1; rd = 5'd9; din = 32'h5555_AAAA; rs1 = 5'd9; rs2 = 5'd1;
    step(); step();
    for (int k = 0; k < 2; k++) begin
      checks += 3;
      if (rdyv[k] !== 1'b0) begin errors++; $display("FAIL reset_ready dut%0d: got %b exp 0", k, rdyv[k]); end
      if (r1v[k] !== '0) begin errors++; $display("FAIL reset_r1 dut%0d: got %h exp 0", k, r1v[k]); end
      if (b1v[k] !== 1'b0) begin errors++; $display("FAIL reset_busy1 dut%0d: got %b exp 0", k, b1v[k]); end
    end
    rst_n = 1'b1; idle();
    for (int e = 0; e < 32; e++) begin
      checks++;
      if (rdyv[0] !== 1'b0 || rdyv[1] !== 1'b0) begin
        errors++; $display("FAIL clear_ready edge%0d: got %b%b exp 00", e, rdyv[0], rdyv[1]);
      end
      step();
    end
    checks++;
    if (rdyv[0] !== 1'b1 || rdyv[1] !== 1'b1) begin
      errors++; $display("FAIL ready_after_32: got %b%b exp 11", rdyv[0], rdyv[1]);
    end
    for (int a = 0; a < 32; a++) begin
      rs1 = 5'(a); rs2 = 5'(31 - a); #1;
      for (int k = 0; k < 2; k++) begin
        checks += 2;
        if (r1v[k] !== '0) begin errors++; $display("FAIL zero_r1 dut%0d reg%0d: got %h exp 0", k, a, r1v[k]); end
        if (r2v[k] !== '0) begin errors++; $display("FAIL zero_r2 dut%0d reg%0d: got %h exp 0", k, 31 - a, r2v[k]); end
      end
    end
  endtask

  task automatic test_bypass();
    wen = 1'b1; rd = 5'd5; din = 32'hDEAD_BEEF; rs1 = 5'd5; #1;
    checks += 2;
    if (r1v[0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bypass_same_cycle: got %h exp deadbeef", r1v[0]); end
    if (r1v[1] !== 32'h0) begin errors++; $display("FAIL nobypass_same_cycle: got %h exp 0", r1v[1]); end
    step(); idle(); #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (r1v[k] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL write_next_cycle dut%0d: got %h exp deadbeef", k, r1v[k]); end
    end
  endtask

  task automatic test_x0();
    wen = 1'b1; rd = 5'd0; din = 32'h1234; rs2 = 5'd0; #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (r2v[k] !== '0) begin errors++; $display("FAIL x0_before dut%0d: got %h exp 0", k, r2v[k]); end
    end
    step(); idle(); #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (r2v[k] !== '0) begin errors++; $display("FAIL x0_after dut%0d: got %h exp 0", k, r2v[k]); end
    end
  endtask

  task automatic test_scoreboard();
    busy_set = 1'b1; busy_rd = 5'd7; rs1 = 5'd7;
    step(); idle(); #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (b1v[k] !== 1'b1) begin errors++; $display("FAIL sb_set dut%0d: got %b exp 1", k, b1v[k]); end
    end
    wen = 1'b1; rd = 5'd7; din = 32'h77; #1;
    checks += 2;
    if (b1v[0] !== 1'b0) begin errors++; $display("FAIL sb_fwd_clear bypass: got %b exp 0", b1v[0]); end
    if (b1v[1] !== 1'b1) begin errors++; $display("FAIL sb_fwd_clear nobypass: got %b exp 1", b1v[1]); end
    step(); idle(); #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (b1v[k] !== 1'b0) begin errors++; $display("FAIL sb_retire dut%0d: got %b exp 0", k, b1v[k]); end
    end
    busy_set = 1'b1; busy_rd = 5'd7; wen = 1'b1; rd = 5'd7; din = 32'h78; #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (b1v[k] !== 1'b0) begin errors++; $display("FAIL sb_tie_before dut%0d: got %b exp 0", k, b1v[k]); end
    end
    step(); idle(); #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (b1v[k] !== 1'b1) begin errors++; $display("FAIL sb_set_wins dut%0d: got %b exp 1", k, b1v[k]); end
    end
    wen = 1'b1; rd = 5'd7; din = 32'h79; step(); idle();
  endtask

  task automatic test_random(input int n);
    for (int c = 0; c < n; c++) begin
      wen = 1'($urandom); busy_set = 1'($urandom); din = $urandom;
      rd      = ($urandom % 2) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      busy_rd = ($urandom % 2) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      rs1     = ($urandom % 2) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      rs2     = ($urandom % 4 == 0) ? rd : 5'($urandom_range(0, 31));
      #1;
      for (int k = 0; k < 2; k++) begin
        checks += 5;
        if (rdyv[k] !== m_ready) begin errors++; $display("FAIL rand_ready dut%0d cyc%0d: got %b exp %b", k, c, rdyv[k], m_ready); end
        if (r1v[k] !== exp_r(rs1, k == 0)) begin errors++; $display("FAIL rand_r1 dut%0d cyc%0d: got %h exp %h", k, c, r1v[k], exp_r(rs1, k == 0)); end
        if (r2v[k] !== exp_r(rs2, k == 0)) begin errors++; $display("FAIL rand_r2 dut%0d cyc%0d: got %h exp %h", k, c, r2v[k], exp_r(rs2, k == 0)); end
        if (b1v[k] !== exp_b(rs1, k == 0)) begin errors++; $display("FAIL rand_busy1 dut%0d cyc%0d: got %b exp %b", k, c, b1v[k], exp_b(rs1, k == 0)); end
        if (b2v[k] !== exp_b(rs2, k == 0)) begin errors++; $display("FAIL rand_busy2 dut%0d cyc%0d: got %b exp %b", k, c, b2v[k], exp_b(rs2, k == 0)); end
      end
      step();
    end
    idle();
  endtask

  task automatic test_clear_ignore();
    wen = 1'b1; rd = 5'd4; din = 32'hAB; busy_set = 1'b1; busy_rd = 5'd4; step();
    rst_n = 1'b0; step(); rst_n = 1'b1;
    for (int e = 0; e < 32; e++) begin
      busy_set = 1'b1; busy_rd = 5'd4; wen = 1'b1; rd = 5'd4; din = 32'hFF;
      rs1 = 5'd4; rs2 = 5'($urandom_range(0, 31)); #1;
      for (int k = 0; k < 2; k++) begin
        checks += 4;
        if (r1v[k] !== '0) begin errors++; $display("FAIL clear_r1 dut%0d edge%0d: got %h exp 0", k, e, r1v[k]); end
        if (r2v[k] !== '0) begin errors++; $display("FAIL clear_r2 dut%0d edge%0d: got %h exp 0", k, e, r2v[k]); end
        if (b1v[k] !== 1'b0) begin errors++; $display("FAIL clear_busy1 dut%0d edge%0d: got %b exp 0", k, e, b1v[k]); end
        if (b2v[k] !== 1'b0) begin errors++; $display("FAIL clear_busy2 dut%0d edge%0d: got %b exp 0", k, e, b2v[k]); end
      end
      step();
    end
    idle(); rs1 = 5'd4; #1;
    for (int k = 0; k < 2; k++) begin
      checks += 3;
      if (rdyv[k] !== 1'b1) begin errors++; $display("FAIL clear_ign_ready dut%0d: got %b exp 1", k, rdyv[k]); end
      if (r1v[k] !== '0) begin errors++; $display("FAIL clear_ign_reg4 dut%0d: got %h exp 0", k, r1v[k]); end
      if (b1v[k] !== 1'b0) begin errors++; $display("FAIL clear_ign_busy4 dut%0d: got %b exp 0", k, b1v[k]); end
    end
  endtask

  task automatic test_reset_mid_clear();
    wen = 1'b1; rd = 5'd3; din = 32'h33; step(); idle();
    rst_n = 1'b0; step(); rst_n = 1'b1;
    for (int e = 0; e < 10; e++) step();
    rst_n = 1'b0; wen = 1'b1; rd = 5'd3; din = 32'hCAFE; step();
    rst_n = 1'b1; idle();
    for (int e = 0; e < 32; e++) begin
      checks++;
      if (rdyv[0] !== 1'b0 || rdyv[1] !== 1'b0) begin
        errors++; $display("FAIL restart_ready edge%0d: got %b%b exp 00", e, rdyv[0], rdyv[1]);
      end
      step();
    end
    rs1 = 5'd3; #1;
    for (int k = 0; k < 2; k++) begin
      checks += 2;
      if (rdyv[k] !== 1'b1) begin errors++; $display("FAIL restart_ready_final dut%0d: got %b exp 1", k, rdyv[k]); end
      if (r1v[k] !== '0) begin errors++; $display("FAIL restart_reg3 dut%0d: got %h exp 0", k, r1v[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_x0();
    test_scoreboard();
    test_random(400);
    test_clear_ignore();
    test_reset_mid_clear();
    test_random(300);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL provide parameters, one per line:
- XLEN, 32, data width in bits.
- NREGS, 32, register count; power of 2, >=2; AW = log2(NREGS).
- BYPASS, 1, 1 = same-cycle write-to-read forwarding, 0 = none.
REQ-002 SHALL have ports, one per line:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- wen  in  1  write enable.
- rd  in  AW  write address.
- din  in  XLEN  write data.
- rs1  in  AW  read address, port 1.
- rs2  in  AW  read address, port 2.
- r1  out  XLEN  read data, port 1.
- r2  out  XLEN  read data, port 2.
- busy_set  in  1  mark register busy_rd as pending (producer issued).
- busy_rd  in  AW  register to mark busy.
- busy1  out  1  rs1 pending-write flag.
- busy2  out  1  rs2 pending-write flag.
- ready  out  1  initialisation complete; block accepts writes.

Function
REQ-003 SHALL implement a 2-state FSM, CLEAR and RUN; rst_n low at a rising edge forces CLEAR with clear counter cnt=0.
REQ-004 In CLEAR, each rising edge with rst_n high SHALL write zero to regs[cnt] and increment cnt; when cnt==NREGS-1 the write completes and the state moves to RUN.
REQ-005 CLEAR SHALL therefore last exactly NREGS cycles after rst_n deasserts; ready SHALL be 0 in CLEAR and 1 in RUN, registered.
REQ-006 In CLEAR, wen and busy_set SHALL be ignored; r1/r2 SHALL read 0; busy1/busy2 SHALL read 0.
REQ-007 rst_n low mid-CLEAR or in RUN SHALL restart CLEAR from cnt=0; register contents are not otherwise guaranteed until ready=1.
REQ-008 In RUN, wen=1 with rd!=0 SHALL write din to regs[rd] at the rising edge; a write to rd=0 SHALL be discarded.
REQ-009 r1/r2 SHALL be combinational reads of regs[rs1]/regs[rs2]; rs=0 SHALL always return 0.
REQ-010 With BYPASS=1 in RUN, if wen=1, rd!=0 and rd==rsN, rN SHALL equal din in the same cycle; with BYPASS=0, rN SHALL return the old value until after the edge.
REQ-011 Scoreboard: one busy bit per register; busy bit 0 is hardwired 0; all bits SHALL be cleared in CLEAR.
REQ-012 In RUN, busy_set=1 with busy_rd!=0 SHALL set busy[busy_rd] at the edge; wen=1 with rd!=0 SHALL clear busy[rd] at the edge.
REQ-013 Simultaneous busy_set and wen to the same register SHALL leave the bit set (set wins: new producer outranks retiring one).
REQ-014 busy1/busy2 SHALL be combinational reads of busy[rs1]/busy[rs2]; with BYPASS=1, a same-cycle write to rsN (no same-cycle set) SHALL force busyN=0.
REQ-015 The counter SHALL be AW bits and SHALL not wrap past NREGS-1 (transition occurs at NREGS-1).

Reset
REQ-016 On rst_n low: state=CLEAR, cnt=0, ready=0, all busy bits 0, r1=r2=0, busy1=busy2=0.
REQ-017 Reset SHALL be synchronous only; no asynchronous path from rst_n to any flop.

Verification
REQ-018 Reset 1 cycle, release, NREGS=32 -> ready=0 for 32 edges, ready=1 after edge 32; all 32 regs read 0.
REQ-019 RUN, wen=1 rd=5 din=0xDEADBEEF, rs1=5, BYPASS=1 -> r1=0xDEADBEEF same cycle; BYPASS=0 -> r1=0 same cycle, 0xDEADBEEF next cycle.
REQ-020 wen=1 rd=0 din=0x1234, rs2=0 -> r2=0 before and after edge.
REQ-021 busy_set rd=7, next cycle rs1=7 -> busy1=1; then wen rd=7 -> busy1=0 after edge; busy_set and wen both rd=7 same cycle -> busy1=1 after edge.
REQ-022 Assert rst_n low at CLEAR cycle 10 while wen=1 rd=3 -> no write; CLEAR restarts; ready after 32 more edges; regs[3]=0.
REQ-023 In CLEAR, busy_set rd=4 and wen rd=4 din=0xFF -> after ready, busy[4]=0, regs[4]=0.
